// File: rtl/multi_ts_acc_corrector_if.sv
// Handshake and bus bundle for multi_ts_acc_corrector.
// Groups the accumulate, correction, spike-memory and result channels.
// Clock and reset are plain ports on the block and are not part of this bundle.
//   slave  : view of the corrector itself
//   master : view of the surrounding datapath / testbench
// Ports carried:
//   acc_valid/acc_weight/acc_ready       pseudo-accumulate channel
//   corr_valid/corr_addr/corr_weight/corr_ready  correction request channel
//   flush                                end-of-row pulse
//   mem_rd_en/mem_addr/mem_rd_data/mem_rd_valid  fibre-A spike word read port
//   result_data/result_valid/result_ready/sat_flag  packed per-timestep results
interface multi_ts_acc_corrector_if #(
  parameter int TIMESTEPS    = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 12,
  parameter int ADDR_WIDTH   = 8
);
  logic                           acc_valid;
  logic [WEIGHT_WIDTH-1:0]        acc_weight;
  logic                           acc_ready;
  logic                           corr_valid;
  logic [ADDR_WIDTH-1:0]          corr_addr;
  logic [WEIGHT_WIDTH-1:0]        corr_weight;
  logic                           corr_ready;
  logic                           flush;
  logic                           mem_rd_en;
  logic [ADDR_WIDTH-1:0]          mem_addr;
  logic [TIMESTEPS-1:0]           mem_rd_data;
  logic                           mem_rd_valid;
  logic [TIMESTEPS*ACC_WIDTH-1:0] result_data;
  logic                           result_valid;
  logic                           result_ready;
  logic                           sat_flag;

  modport slave (
    input  acc_valid, acc_weight, corr_valid, corr_addr, corr_weight, flush,
           mem_rd_data, mem_rd_valid, result_ready,
    output acc_ready, corr_ready, mem_rd_en, mem_addr, result_data,
           result_valid, sat_flag
  );

  modport master (
    output acc_valid, acc_weight, corr_valid, corr_addr, corr_weight, flush,
           mem_rd_data, mem_rd_valid, result_ready,
    input  acc_ready, corr_ready, mem_rd_en, mem_addr, result_data,
           result_valid, sat_flag
  );
endinterface

// File: rtl/multi_ts_acc_corrector.sv
// Pseudo-accumulator and correction engine for the sparse SNN datapath.
// Matched weights are summed into one pseudo-sum as if every timestep fired.
// Corrections are queued and, one at a time, the fibre-A spike word is read
// and the weight is accumulated into corr[t] for every timestep that did not
// fire. At end of row the block presents sat(pseudo - corr[t]) per timestep.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  slave view of multi_ts_acc_corrector_if (acc, corr, flush, memory
//        read, result channels and sticky sat_flag)
module multi_ts_acc_corrector #(
  parameter int TIMESTEPS    = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 12,
  parameter int ADDR_WIDTH   = 8,
  parameter int CORR_DEPTH   = 4
) (
  input logic                    clk,
  input logic                    rst,
  multi_ts_acc_corrector_if.slave bus
);

  localparam int PTR_W = (CORR_DEPTH > 1) ? $clog2(CORR_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, APPLY, OUTPUT} state_t;

  state_t                         state;
  logic [ACC_WIDTH-1:0]           pseudo;
  logic [ACC_WIDTH-1:0]           corr [TIMESTEPS];
  logic [ADDR_WIDTH-1:0]          q_addr [CORR_DEPTH];
  logic [WEIGHT_WIDTH-1:0]        q_weight [CORR_DEPTH];
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [CNT_W-1:0]               count;
  logic                           flush_pending;
  logic [WEIGHT_WIDTH-1:0]        cur_weight;
  logic [TIMESTEPS-1:0]           spike;
  logic                           mem_rd_en_q;
  logic [ADDR_WIDTH-1:0]          mem_addr_q;
  logic [TIMESTEPS*ACC_WIDTH-1:0] result_q;
  logic                           result_valid_q;
  logic                           sat_q;

  logic                           q_full;
  logic                           q_empty;
  logic                           acc_fire;
  logic                           push;
  logic                           pop;
  logic                           accepting;
  logic [ACC_WIDTH:0]             acc_wide;
  logic [ACC_WIDTH:0]             corr_wide [TIMESTEPS];
  logic [ACC_WIDTH:0]             res_wide [TIMESTEPS];
  logic [TIMESTEPS*ACC_WIDTH-1:0] res_vec;
  logic                           res_ovf;

  // One guard bit above the accumulator is enough to detect any single
  // add/subtract overflow of two in-range operands.
  function automatic logic [ACC_WIDTH:0] ext_w(input logic [WEIGHT_WIDTH-1:0] w);
    ext_w = {{(ACC_WIDTH+1-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
  endfunction

  function automatic logic [ACC_WIDTH:0] ext_a(input logic [ACC_WIDTH-1:0] a);
    ext_a = {a[ACC_WIDTH-1], a};
  endfunction

  function automatic logic ovf(input logic [ACC_WIDTH:0] v);
    ovf = v[ACC_WIDTH] ^ v[ACC_WIDTH-1];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] clip(input logic [ACC_WIDTH:0] v);
    if (ovf(v)) clip = v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else        clip = v[ACC_WIDTH-1:0];
  endfunction

  // Both request channels close once a flush is latched or results are
  // being presented, so nothing from the next row leaks into this one.
  assign accepting = !flush_pending && (state != OUTPUT);
  assign q_full    = (count == CNT_W'(CORR_DEPTH));
  assign q_empty   = (count == '0);
  assign acc_fire  = bus.acc_valid && accepting;
  assign push      = bus.corr_valid && accepting && !q_full;
  assign pop       = (state == IDLE) && !q_empty;

  assign bus.acc_ready    = accepting;
  assign bus.corr_ready   = accepting && !q_full;
  assign bus.mem_rd_en    = mem_rd_en_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.result_data  = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.sat_flag     = sat_q;

  // Saturating candidates for every datapath update, plus the packed
  // end-of-row results and whether any lane clipped.
  always_comb begin
    res_ovf  = 1'b0;
    res_vec  = '0;
    acc_wide = ext_a(pseudo) + ext_w(bus.acc_weight);
    for (int t = 0; t < TIMESTEPS; t++) begin
      corr_wide[t] = ext_a(corr[t]) + ext_w(cur_weight);
      res_wide[t]  = ext_a(pseudo) - ext_a(corr[t]);
      res_vec[t*ACC_WIDTH +: ACC_WIDTH] = clip(res_wide[t]);
      res_ovf = res_ovf | ovf(res_wide[t]);
    end
  end

  // Accumulate path, correction queue and correction/output state machine.
  // They share one block because the result handshake clears registers
  // that the accumulate and apply paths otherwise own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pseudo         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      flush_pending  <= 1'b0;
      cur_weight     <= '0;
      spike          <= '0;
      mem_rd_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sat_q          <= 1'b0;
      for (int t = 0; t < TIMESTEPS; t++) corr[t] <= '0;
      for (int i = 0; i < CORR_DEPTH; i++) begin
        q_addr[i]   <= '0;
        q_weight[i] <= '0;
      end
    end else begin
      mem_rd_en_q <= 1'b0;

      if (acc_fire) begin
        pseudo <= clip(acc_wide);
        if (ovf(acc_wide)) sat_q <= 1'b1;
      end

      if (bus.flush && accepting) flush_pending <= 1'b1;

      if (push) begin
        q_addr[wr_ptr]   <= bus.corr_addr;
        q_weight[wr_ptr] <= bus.corr_weight;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (!q_empty) begin
            mem_addr_q  <= q_addr[rd_ptr];
            cur_weight  <= q_weight[rd_ptr];
            rd_ptr      <= rd_ptr + PTR_W'(1);
            mem_rd_en_q <= 1'b1;
            state       <= ISSUE;
          end else if (flush_pending) begin
            result_q       <= res_vec;
            result_valid_q <= 1'b1;
            if (res_ovf) sat_q <= 1'b1;
            state          <= OUTPUT;
          end
        end
        ISSUE: state <= WAIT_DATA;
        WAIT_DATA: begin
          if (bus.mem_rd_valid) begin
            spike <= bus.mem_rd_data;
            state <= APPLY;
          end
        end
        APPLY: begin
          // Timesteps that did not spike must not see this weight.
          for (int t = 0; t < TIMESTEPS; t++) begin
            if (!spike[t]) begin
              corr[t] <= clip(corr_wide[t]);
              if (ovf(corr_wide[t])) sat_q <= 1'b1;
            end
          end
          state <= IDLE;
        end
        OUTPUT: begin
          if (bus.result_ready) begin
            pseudo         <= '0;
            flush_pending  <= 1'b0;
            sat_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            for (int t = 0; t < TIMESTEPS; t++) corr[t] <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_ts_acc_corrector.sv
// Self-checking bench for multi_ts_acc_corrector.
// A row model built from plain integer arithmetic predicts each result
// vector and sat_flag at the moment a flush is accepted; a monitor process
// compares whatever the block presents. A memory responder serves spike
// words from a bench-owned array and checks read order and strobe width.
module tb_multi_ts_acc_corrector;

  localparam int T   = 4;
  localparam int WW  = 8;
  localparam int AW  = 12;
  localparam int ADW = 8;
  localparam int CD  = 4;
  localparam int ACC_MAX = (1 << (AW - 1)) - 1;
  localparam int ACC_MIN = -(1 << (AW - 1));

  logic clk = 1'b0;
  logic rst = 1'b0;

  multi_ts_acc_corrector_if #(.TIMESTEPS(T), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW),
                              .ADDR_WIDTH(ADW)) bus ();

  multi_ts_acc_corrector #(.TIMESTEPS(T), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW),
                           .ADDR_WIDTH(ADW), .CORR_DEPTH(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [T-1:0] spike_mem [256];

  int row_acc[$];
  int row_caddr[$];
  int row_cw[$];
  int exp_addr[$];
  logic [T*AW-1:0] sb_data[$];
  bit sb_sat[$];

  bit mem_hold  = 1'b0;
  bit stray_req = 1'b0;
  bit bp_hold   = 1'b0;
  int fixed_lat = 1;
  bit pend      = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic failBound(input string name);
    n_checks++;
    $display("[TB] FAIL %s: bound expired, got timeout, expected event", name);
  endtask

  function automatic int clampv(input int v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  // End-of-row reference: saturating sums in arrival order, then lanes.
  task automatic computeRow();
    int p;
    int c[T];
    int r;
    bit s;
    logic [T*AW-1:0] res_vec;
    p = 0;
    s = 1'b0;
    foreach (row_acc[i]) begin
      r = p + row_acc[i];
      p = clampv(r);
      if (p != r) s = 1'b1;
    end
    for (int t = 0; t < T; t++) c[t] = 0;
    foreach (row_caddr[i]) begin
      for (int t = 0; t < T; t++) begin
        if (spike_mem[row_caddr[i]][t] == 1'b0) begin
          r = c[t] + row_cw[i];
          c[t] = clampv(r);
          if (c[t] != r) s = 1'b1;
        end
      end
    end
    res_vec = '0;
    for (int t = 0; t < T; t++) begin
      r = clampv(p - c[t]);
      if (r != p - c[t]) s = 1'b1;
      res_vec[t*AW +: AW] = AW'(r);
    end
    sb_data.push_back(res_vec);
    sb_sat.push_back(s);
    row_acc.delete();
    row_caddr.delete();
    row_cw.delete();
  endtask

  // One cycle of drive; acceptance is judged from the ready levels that
  // will be seen at the coming edge.
  task automatic applyStimulus(input bit do_acc, input int aw, input bit do_corr,
                               input int ca, input int cw, input bit do_flush,
                               output bit acc_ok, output bit corr_ok, output bit flush_ok);
    bus.acc_valid   = do_acc;
    bus.acc_weight  = WW'(aw);
    bus.corr_valid  = do_corr;
    bus.corr_addr   = ADW'(ca);
    bus.corr_weight = WW'(cw);
    bus.flush       = do_flush;
    @(negedge clk);
    acc_ok   = do_acc && bus.acc_ready;
    corr_ok  = do_corr && bus.corr_ready;
    flush_ok = do_flush && bus.acc_ready;
    if (acc_ok) row_acc.push_back(aw);
    if (corr_ok) begin
      row_caddr.push_back(ca);
      row_cw.push_back(cw);
      exp_addr.push_back(ca);
    end
    if (flush_ok) computeRow();
    @(posedge clk);
    #1;
    bus.acc_valid  = 1'b0;
    bus.corr_valid = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic doAcc(input int w);
    bit a, c, f;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, w, 1'b0, 0, 0, 1'b0, a, c, f);
      if (a) return;
    end
    failBound("acc_accept");
  endtask

  task automatic doCorr(input int ad, input int w);
    bit a, c, f;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 0, 1'b1, ad, w, 1'b0, a, c, f);
      if (c) return;
    end
    failBound("corr_accept");
  endtask

  task automatic doFlush(input bit rnd_ops);
    bit a, c, f;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(rnd_ops && ($urandom_range(0, 1) == 1), int'($signed(8'($urandom))),
                    rnd_ops && ($urandom_range(0, 1) == 1), int'($urandom_range(0, 255)),
                    int'($signed(8'($urandom))), 1'b1, a, c, f);
      if (f) return;
    end
    failBound("flush_accept");
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb_data.size() == 0) begin
        repeat (3) @(posedge clk);
        #1;
        return;
      end
    end
    failBound("result_drain");
    sb_data.delete();
    sb_sat.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_acc_ready"}, bus.acc_ready, 1);
    checkOutput({tag, "_corr_ready"}, bus.corr_ready, 1);
    checkOutput({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
    checkOutput({tag, "_mem_addr"}, bus.mem_addr, 0);
    checkOutput({tag, "_result_valid"}, bus.result_valid, 0);
    checkOutput({tag, "_result_data"}, bus.result_data, 0);
    checkOutput({tag, "_sat_flag"}, bus.sat_flag, 0);
  endtask

  // Result consumer pacing.
  initial begin
    bus.result_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.result_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Spike memory: answers each strobe after a latency, checks order/pulse.
  initial begin
    int wait_cnt;
    int req_addr;
    bit prev_en;
    wait_cnt = 0;
    req_addr = 0;
    prev_en  = 1'b0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rd_valid = 1'b0;
      if (!rst) begin
        pend    = 1'b0;
        prev_en = 1'b0;
        continue;
      end
      if (stray_req) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = T'($urandom);
        stray_req        = 1'b0;
      end else if (pend && !mem_hold) begin
        if (wait_cnt == 0) begin
          bus.mem_rd_valid = 1'b1;
          bus.mem_rd_data  = spike_mem[req_addr];
          pend             = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      if (bus.mem_rd_en) begin
        checkOutput("rd_en_single_pulse", prev_en, 0);
        if (exp_addr.size() == 0) failBound("read_expected");
        else checkOutput("mem_addr_order", bus.mem_addr, exp_addr.pop_front());
        pend     = 1'b1;
        req_addr = int'(bus.mem_addr);
        wait_cnt = (fixed_lat > 0) ? fixed_lat - 1 : int'($urandom_range(0, 2));
      end
      prev_en = bus.mem_rd_en;
    end
  end

  // Result monitor: compares against the scoreboard, checks hold-stability
  // under backpressure and the post-handshake clear.
  initial begin
    logic [T*AW-1:0] held_data;
    bit held_sat;
    bit have_hold;
    bit clear_chk;
    have_hold = 1'b0;
    clear_chk = 1'b0;
    held_data = '0;
    held_sat  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_hold = 1'b0;
        clear_chk = 1'b0;
        continue;
      end
      if (clear_chk) begin
        checkOutput("sat_cleared", bus.sat_flag, 0);
        checkOutput("valid_dropped", bus.result_valid, 0);
        checkOutput("acc_ready_back", bus.acc_ready, 1);
        clear_chk = 1'b0;
      end
      if (bus.result_valid) begin
        checkOutput("acc_ready_in_output", bus.acc_ready, 0);
        if (have_hold) begin
          checkOutput("held_result_data", bus.result_data, held_data);
          checkOutput("held_sat_flag", bus.sat_flag, held_sat);
        end
        held_data = bus.result_data;
        held_sat  = bus.sat_flag;
        if (bus.result_ready) begin
          if (sb_data.size() == 0) begin
            failBound("result_expected");
          end else begin
            checkOutput("result_data", bus.result_data, sb_data.pop_front());
            checkOutput("result_sat_flag", bus.sat_flag, sb_sat.pop_front());
          end
          have_hold = 1'b0;
          clear_chk = 1'b1;
        end else begin
          have_hold = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit a, c, f;
    int n;
    bus.acc_valid   = 1'b0;
    bus.acc_weight  = '0;
    bus.corr_valid  = 1'b0;
    bus.corr_addr   = '0;
    bus.corr_weight = '0;
    bus.flush       = 1'b0;
    for (int i = 0; i < 256; i++) spike_mem[i] = T'($urandom);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic correction: 25 with weight 12 removed where 4'b1010 has zeros.
    $display("[TB] basic correction");
    spike_mem[5] = 4'b1010;
    fixed_lat = 1;
    doAcc(25);
    doCorr(5, 12);
    doFlush(1'b0);
    waitDrain();

    // Multiple operations: 40+15, one fully-active and one fully-idle word.
    $display("[TB] multiple operations");
    spike_mem[10] = 4'b1111;
    spike_mem[11] = 4'b0000;
    doAcc(40);
    doAcc(15);
    doCorr(10, 10);
    doCorr(11, 5);
    doFlush(1'b0);
    waitDrain();

    // Queue full: memory stalled, one entry in flight plus CD queued.
    $display("[TB] queue full");
    mem_hold = 1'b1;
    n = 0;
    for (int i = 1; i <= CD + 1; i++) begin
      applyStimulus(1'b0, 0, 1'b1, i, int'($urandom_range(1, 20)), 1'b0, a, c, f);
      if (c) n++;
    end
    checkOutput("queue_fill_accepted", n, CD + 1);
    @(negedge clk);
    checkOutput("queue_full_corr_ready", bus.corr_ready, 0);
    @(posedge clk);
    #1;
    mem_hold = 1'b0;
    doFlush(1'b0);
    waitDrain();

    // Saturation: 17 x 127 exceeds the 12-bit range.
    $display("[TB] saturation");
    repeat (17) doAcc(127);
    doFlush(1'b0);
    waitDrain();

    // Backpressure: results held while acc_valid is kept high.
    $display("[TB] backpressure");
    bp_hold = 1'b1;
    doAcc(int'($urandom_range(1, 100)));
    doCorr(int'($urandom_range(0, 255)), int'($urandom_range(1, 50)));
    doFlush(1'b0);
    n = 0;
    while (!bus.result_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) failBound("bp_result_valid");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1, 1'b0, 0, 0, 1'b0, a, c, f);
      checkOutput("bp_acc_blocked", a, 0);
    end
    bp_hold = 1'b0;
    doAcc(7);
    doFlush(1'b0);
    waitDrain();

    // Reset mid-read, then a stray read response that must be ignored.
    $display("[TB] reset mid-read");
    mem_hold = 1'b1;
    doAcc(33);
    doCorr(20, 9);
    n = 0;
    while (!pend && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) failBound("read_issue");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("midread_reset");
    row_acc.delete();
    row_caddr.delete();
    row_cw.delete();
    exp_addr.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_hold = 1'b0;
    stray_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stray_no_read", bus.mem_rd_en, 0);
    end
    @(posedge clk);
    #1;
    doAcc(60);
    doCorr(21, 11);
    doFlush(1'b0);
    waitDrain();

    // Randomised rows with overlapping traffic and random memory latency.
    $display("[TB] random rows");
    fixed_lat = 0;
    for (int r = 0; r < 25; r++) begin
      int nops;
      nops = int'($urandom_range(0, 8));
      for (int k = 0; k < nops; k++) begin
        applyStimulus($urandom_range(0, 1) == 1, int'($signed(8'($urandom))),
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
                      int'($signed(8'($urandom))), 1'b0, a, c, f);
      end
      doFlush(1'b1);
    end
    waitDrain();

    checkOutput("reads_outstanding", exp_addr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
